// File: rtl/tdm_pkg.sv
// Shared definitions for the 8-channel select/distribute receive link.
//   N_CH        : number of link channels
//   SEL_W       : width of the channel select {A,B,C}
//   state_e     : receiver FSM states
//   sel_to_bits : maps a channel number to the {A,B,C} select pins (A = MSB)
package tdm_pkg;

  localparam int N_CH  = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  function automatic logic [SEL_W-1:0] sel_to_bits(input logic [SEL_W-1:0] ch);
    return {ch[2], ch[1], ch[0]};
  endfunction

endpackage

// File: rtl/tdm_scan_counter.sv
// Channel/dwell counter for the scan receiver.
//   clk, rst : clock, asynchronous active-high reset
//   run      : advance the dwell count (scanning)
//   clear    : force ch=0, dwell count=0 (takes priority over run)
//   ch       : currently selected channel, 0..7
//   sample   : last dwell cycle of the current channel
//   last     : sample strobe of channel 7 (frame end)
import tdm_pkg::*;

module tdm_scan_counter #(
  parameter int DWELL = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             clear,
  output logic [SEL_W-1:0] ch,
  output logic             sample,
  output logic             last
);

  // At least one bit even when DWELL=1.
  localparam int CNT_W = (DWELL < 2) ? 1 : $clog2(DWELL + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] ch_q, ch_d;

  always_comb begin
    sample = run && (cnt_q == CNT_LAST);
    last   = sample && (ch_q == SEL_W'(N_CH - 1));
    cnt_d  = cnt_q;
    ch_d   = ch_q;
    if (clear) begin
      cnt_d = '0;
      ch_d  = '0;
    end else if (run) begin
      if (sample) begin
        cnt_d = '0;
        // 7 -> 0 wrap happens only here, i.e. at frame end.
        ch_d  = ch_q + 3'd1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // ---- counter register stage ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      ch_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      ch_q  <= ch_d;
    end
  end

  assign ch = ch_q;

endmodule

// File: rtl/tdm_scan_receiver8.sv
// Receive end of the 8-channel select/distribute link.
// Drives the channel select {oA,oB,oC}, samples the addressed line on each
// channel's last dwell cycle, assembles an 8-bit frame and flags frames in
// which an unselected line (idle-high) was seen low.
//   clk, rst     : clock, asynchronous active-high reset
//   iStart       : request one frame scan (honoured in IDLE only)
//   iCont        : continuous mode, looked at on frame end
//   iLine[7:0]   : link lines from the transmit side
//   oA,oB,oC     : channel select, oA is the MSB
//   oData[7:0]   : last completed frame, bit k = channel k sample
//   oValid       : one-cycle pulse when oData/oErr update
//   oErr         : protocol error flag of the frame in oData
//   oBusy        : high while scanning
import tdm_pkg::*;

module tdm_scan_receiver8 #(
  parameter int DWELL = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iStart,
  input  logic            iCont,
  input  logic [N_CH-1:0] iLine,
  output logic            oA,
  output logic            oB,
  output logic            oC,
  output logic [N_CH-1:0] oData,
  output logic            oValid,
  output logic            oErr,
  output logic            oBusy
);

  state_e state_q, state_d;

  logic [N_CH-1:0]  shadow_q, shadow_d;
  logic             ferr_q, ferr_d;
  logic [N_CH-1:0]  data_q, data_d;
  logic             err_q, err_d;
  logic             valid_q, valid_d;

  logic [SEL_W-1:0] ch;
  logic             sample;
  logic             last;
  logic             run;
  logic             clear;
  logic [N_CH-1:0]  ch_mask;
  logic             err_now;
  logic [SEL_W-1:0] sel;

  assign run   = (state_q == SCAN);
  assign clear = (state_q == IDLE);

  tdm_scan_counter #(
    .DWELL (DWELL)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .run    (run),
    .clear  (clear),
    .ch     (ch),
    .sample (sample),
    .last   (last)
  );

  // Any unselected line low is a protocol violation.
  assign ch_mask = N_CH'(1) << ch;
  assign err_now = ((iLine | ch_mask) != {N_CH{1'b1}});

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    ferr_d   = ferr_q;
    data_d   = data_q;
    err_d    = err_q;
    valid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        shadow_d = '0;
        ferr_d   = 1'b0;
        if (iStart) begin
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (sample) begin
          shadow_d[ch] = iLine[ch];
          ferr_d       = ferr_q | err_now;
        end
        if (last) begin
          // Channel 7 goes straight to the output, bypassing the shadow.
          data_d   = {iLine[N_CH-1], shadow_q[N_CH-2:0]};
          err_d    = ferr_q | err_now;
          valid_d  = 1'b1;
          shadow_d = '0;
          ferr_d   = 1'b0;
          if (!iCont) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---- state / frame register stage ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      ferr_q   <= 1'b0;
      data_q   <= '0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      ferr_q   <= ferr_d;
      data_q   <= data_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
    end
  end

  assign sel    = (state_q == SCAN) ? sel_to_bits(ch) : '0;
  assign oA     = sel[2];
  assign oB     = sel[1];
  assign oC     = sel[0];
  assign oBusy  = (state_q == SCAN);
  assign oData  = data_q;
  assign oErr   = err_q;
  assign oValid = valid_q;

endmodule

// File: tb/tb_tdm_scan_receiver8.sv
module tb_tdm_scan_receiver8;

  logic       clk;
  logic       rst;

  // DWELL=2 instance
  logic       start2, cont2;
  logic [7:0] line2, pat2, force2;
  logic       a2, b2, c2, valid2, err2, busy2;
  logic [7:0] data2;
  logic [2:0] sel2;

  // DWELL=1 instance
  logic       start1, cont1;
  logic [7:0] line1, pat1;
  logic       a1, b1, c1, valid1, err1, busy1;
  logic [7:0] data1;
  logic [2:0] sel1;

  int checks;
  int failures;

  tdm_scan_receiver8 #(.DWELL(2)) dut2 (
    .clk(clk), .rst(rst), .iStart(start2), .iCont(cont2), .iLine(line2),
    .oA(a2), .oB(b2), .oC(c2), .oData(data2), .oValid(valid2),
    .oErr(err2), .oBusy(busy2)
  );

  tdm_scan_receiver8 #(.DWELL(1)) dut1 (
    .clk(clk), .rst(rst), .iStart(start1), .iCont(cont1), .iLine(line1),
    .oA(a1), .oB(b1), .oC(c1), .oData(data1), .oValid(valid1),
    .oErr(err1), .oBusy(busy1)
  );

  // Transmit-side model: selected line carries its data bit, others idle high.
  function automatic logic [7:0] tx(input logic [7:0] pat, input logic [2:0] s);
    logic [7:0] r;
    r    = 8'hFF;
    r[s] = pat[s];
    return r;
  endfunction

  assign sel2  = {a2, b2, c2};
  assign sel1  = {a1, b1, c1};
  assign line2 = tx(pat2, sel2) & ~force2;
  assign line1 = tx(pat1, sel1);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle2(input string tag);
    check({tag, "_busy"}, 32'(busy2), 32'd0);
    check({tag, "_sel"},  32'(sel2),  32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b0;
    start2 = 1'b0; cont2 = 1'b0; pat2 = 8'hFF; force2 = 8'h00;
    start1 = 1'b0; cont1 = 1'b0; pat1 = 8'hFF;

    // 1. Asynchronous reset between clock edges
    #2 rst = 1'b1;
    #1;
    check("rst_busy",  32'(busy2),  32'd0);
    check("rst_sel",   32'(sel2),   32'd0);
    check("rst_data",  32'(data2),  32'd0);
    check("rst_valid", 32'(valid2), 32'd0);
    check("rst_err",   32'(err2),   32'd0);
    check("rst_busy1", 32'(busy1),  32'd0);
    check("rst_data1", 32'(data1),  32'd0);
    tick();
    rst = 1'b0;
    tick();
    check_idle2("post_rst");
    check("post_rst_valid", 32'(valid2), 32'd0);

    // 2. Single frame 8'hA5, DWELL=2
    pat2   = 8'hA5;
    start2 = 1'b1;
    tick();                       // E0
    start2 = 1'b0;
    check("f1_busy", 32'(busy2), 32'd1);
    check("f1_sel0", 32'(sel2),  32'd0);
    for (int i = 1; i < 16; i++) begin
      tick();
      check("f1_sel",   32'(sel2),   32'(i / 2));
      check("f1_novld", 32'(valid2), 32'd0);
    end
    tick();                       // E0+16
    check("f1_valid", 32'(valid2), 32'd1);
    check("f1_data",  32'(data2),  32'hA5);
    check("f1_err",   32'(err2),   32'd0);
    check_idle2("f1_end");
    tick();
    check("f1_pulse", 32'(valid2), 32'd0);
    check("f1_hold",  32'(data2),  32'hA5);

    // 3. Continuous mode: 3C then FF, iCont cleared during frame 2
    pat2   = 8'h3C;
    cont2  = 1'b1;
    start2 = 1'b1;
    tick();                       // E0
    start2 = 1'b0;
    for (int i = 1; i < 16; i++) begin
      tick();
      check("c1_busy", 32'(busy2), 32'd1);
    end
    tick();                       // E0+16
    check("c1_valid", 32'(valid2), 32'd1);
    check("c1_data",  32'(data2),  32'h3C);
    check("c1_err",   32'(err2),   32'd0);
    check("c1_busy",  32'(busy2),  32'd1);
    check("c1_sel",   32'(sel2),   32'd0);
    pat2 = 8'hFF;
    for (int i = 17; i < 32; i++) begin
      tick();
      if (i == 20) cont2 = 1'b0;
      check("c2_busy",  32'(busy2),  32'd1);
      check("c2_novld", 32'(valid2), 32'd0);
    end
    tick();                       // E0+32
    check("c2_valid", 32'(valid2), 32'd1);
    check("c2_data",  32'(data2),  32'hFF);
    check_idle2("c2_end");
    tick();
    check("c2_pulse", 32'(valid2), 32'd0);
    check_idle2("c2_after");

    // 4. Protocol error on an unselected line during ch2's sample cycle
    pat2   = 8'h00;
    start2 = 1'b1;
    tick();                       // E0
    start2 = 1'b0;
    ticks(5);                     // E0+5: ch2, last dwell cycle
    check("e_sel", 32'(sel2), 32'd2);
    force2 = 8'h20;
    tick();                       // E0+6: ch2 sampled
    force2 = 8'h00;
    ticks(10);                    // E0+16
    check("e_valid", 32'(valid2), 32'd1);
    check("e_data",  32'(data2),  32'h00);
    check("e_err",   32'(err2),   32'd1);
    tick();
    check("e_errhold", 32'(err2), 32'd1);
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    ticks(16);
    check("e2_valid", 32'(valid2), 32'd1);
    check("e2_data",  32'(data2),  32'h00);
    check("e2_err",   32'(err2),   32'd0);

    // 5. Reset mid-frame at ch=4, then a fresh 8'h5A frame
    pat2   = 8'hA5;
    start2 = 1'b1;
    tick();                       // E0
    start2 = 1'b0;
    ticks(8);
    check("r_sel4", 32'(sel2), 32'd4);
    #2 rst = 1'b1;
    #1;
    check_idle2("r_mid");
    check("r_data",  32'(data2),  32'd0);
    check("r_valid", 32'(valid2), 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("r_novld", 32'(valid2), 32'd0);
      check("r_nobusy", 32'(busy2), 32'd0);
    end
    pat2   = 8'h5A;
    start2 = 1'b1;
    tick();                       // E0'
    start2 = 1'b0;
    ticks(15);
    check("r2_novld", 32'(valid2), 32'd0);
    tick();                       // E0'+16
    check("r2_valid", 32'(valid2), 32'd1);
    check("r2_data",  32'(data2),  32'h5A);
    check("r2_err",   32'(err2),   32'd0);

    // 6. DWELL=1, stray iStart during SCAN, then held iStart
    pat1   = 8'hC3;
    start1 = 1'b1;
    tick();                       // E0
    start1 = 1'b0;
    check("d1_sel0", 32'(sel1), 32'd0);
    for (int k = 1; k < 8; k++) begin
      if (k == 3) start1 = 1'b1;
      tick();
      start1 = 1'b0;
      check("d1_sel",   32'(sel1),   32'(k));
      check("d1_novld", 32'(valid1), 32'd0);
    end
    tick();                       // E0+8
    check("d1_valid", 32'(valid1), 32'd1);
    check("d1_data",  32'(data1),  32'hC3);
    check("d1_err",   32'(err1),   32'd0);
    check("d1_idle",  32'(busy1),  32'd0);

    pat1   = 8'h96;
    start1 = 1'b1;
    tick();                       // E0
    ticks(7);
    check("h_novld", 32'(valid1), 32'd0);
    tick();                       // E0+8
    check("h_valid", 32'(valid1), 32'd1);
    check("h_data",  32'(data1),  32'h96);
    check("h_idle",  32'(busy1),  32'd0);
    tick();                       // E0+9: restarted from IDLE
    check("h_restart", 32'(busy1), 32'd1);
    check("h_sel0",    32'(sel1),  32'd0);
    check("h_pulse",   32'(valid1), 32'd0);
    pat1   = 8'h69;
    start1 = 1'b0;
    ticks(8);                     // E0+17
    check("h2_valid", 32'(valid1), 32'd1);
    check("h2_data",  32'(data1),  32'h69);
    tick();
    check("h2_idle",  32'(busy1),  32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
